// File: rtl/rsa_sequencer.sv
// rsa_sequencer: sequences RSA jobs through the inverter and mod-exp control, with key cache and watchdog.
// Ports: req_* accept a job (primes, direction, message); ctl_* carry registered operands and start
// pulses to the control block and return its finish flags and result; rsp_* present the result or a
// watchdog abort; busy is high whenever a job is in flight.
module rsa_sequencer #(
    parameter int WIDTH          = 128,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_p,
    input  logic [WIDTH-1:0]   req_q,
    input  logic               req_encrypt_decrypt,
    input  logic [2*WIDTH-1:0] req_msg,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_msg,
    output logic               rsp_timeout,
    output logic [WIDTH-1:0]   ctl_p,
    output logic [WIDTH-1:0]   ctl_q,
    output logic               ctl_encrypt_decrypt,
    output logic [2*WIDTH-1:0] ctl_msg_in,
    output logic               ctl_reset_inverter,
    output logic               ctl_reset_mod_exp,
    input  logic               ctl_inverter_finish,
    input  logic               ctl_mod_exp_finish,
    input  logic [2*WIDTH-1:0] ctl_msg_out,
    output logic               busy
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT, RESP} state_t;

    state_t           r_state, w_next;
    logic             r_key_valid;
    logic [WIDTH-1:0] r_cached_p, r_cached_q;
    logic [CW-1:0]    r_wd;
    logic             w_accept, w_hit, w_wait, w_fin, w_done, w_tmo;

    assign w_accept = req_valid & req_ready;
    assign w_hit    = r_key_valid & (req_p == r_cached_p) & (req_q == r_cached_q);
    assign w_wait   = (r_state == INV_WAIT) || (r_state == EXP_WAIT);
    assign w_fin    = (r_state == INV_WAIT) ? ctl_inverter_finish : ctl_mod_exp_finish;
    // r_wd is zero only in the first WAIT cycle, where the finish flag may be left over from the last job
    assign w_done   = w_wait & (r_wd != '0) & w_fin;
    assign w_tmo    = w_wait & (r_wd == WD_LAST) & ~w_done;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_accept ? (w_hit ? EXP_RST : INV_RST) : IDLE;
            INV_RST:  w_next = INV_WAIT;
            INV_WAIT: w_next = w_done ? EXP_RST : (w_tmo ? RESP : INV_WAIT);
            EXP_RST:  w_next = EXP_WAIT;
            EXP_WAIT: w_next = (w_done | w_tmo) ? RESP : EXP_WAIT;
            RESP:     w_next = rsp_ready ? IDLE : RESP;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready          = (r_state == IDLE) & ~reset;
        busy               = r_state != IDLE;
        rsp_valid          = r_state == RESP;
        ctl_reset_inverter = r_state == INV_RST;
        ctl_reset_mod_exp  = r_state == EXP_RST;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_valid         <= 1'b0;
            r_cached_p          <= '0;
            r_cached_q          <= '0;
            r_wd                <= '0;
            ctl_p               <= '0;
            ctl_q               <= '0;
            ctl_encrypt_decrypt <= 1'b0;
            ctl_msg_in          <= '0;
            rsp_msg             <= '0;
            rsp_timeout         <= 1'b0;
        end else begin
            r_wd <= w_wait ? r_wd + 1'b1 : '0;
            if (w_accept) begin
                ctl_p               <= req_p;
                ctl_q               <= req_q;
                ctl_encrypt_decrypt <= req_encrypt_decrypt;
                ctl_msg_in          <= req_msg;
                if (!w_hit) begin
                    r_cached_p  <= req_p;
                    r_cached_q  <= req_q;
                    r_key_valid <= 1'b0;
                end
            end
            if (w_done && r_state == INV_WAIT)
                r_key_valid <= 1'b1;
            if (w_done && r_state == EXP_WAIT) begin
                rsp_msg     <= ctl_msg_out;
                rsp_timeout <= 1'b0;
            end
            // a key whose job timed out is not trusted for reuse
            if (w_tmo) begin
                rsp_msg     <= '0;
                rsp_timeout <= 1'b1;
                r_key_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rsa_sequencer.sv
// tb_rsa_sequencer: directed checks of rsa_sequencer against an XOR-cipher control stub.
module tb_rsa_sequencer;
    localparam int W  = 128;
    localparam int TW = 2 * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_p = '0;
    logic [W-1:0]  req_q = '0;
    logic          req_encrypt_decrypt = 1'b0;
    logic [TW-1:0] req_msg = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [TW-1:0] rsp_msg;
    logic          rsp_timeout;
    logic [W-1:0]  ctl_p, ctl_q;
    logic          ctl_encrypt_decrypt;
    logic [TW-1:0] ctl_msg_in, ctl_msg_out;
    logic          ctl_reset_inverter, ctl_reset_mod_exp;
    logic          ctl_inverter_finish, ctl_mod_exp_finish;
    logic          busy;

    always #5 clk = ~clk;

    rsa_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_p(req_p), .req_q(req_q),
        .req_encrypt_decrypt(req_encrypt_decrypt), .req_msg(req_msg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_msg(rsp_msg), .rsp_timeout(rsp_timeout),
        .ctl_p(ctl_p), .ctl_q(ctl_q),
        .ctl_encrypt_decrypt(ctl_encrypt_decrypt), .ctl_msg_in(ctl_msg_in),
        .ctl_reset_inverter(ctl_reset_inverter), .ctl_reset_mod_exp(ctl_reset_mod_exp),
        .ctl_inverter_finish(ctl_inverter_finish), .ctl_mod_exp_finish(ctl_mod_exp_finish),
        .ctl_msg_out(ctl_msg_out), .busy(busy)
    );

    // control stub: finish 3 cycles after its start pulse, held until the next pulse;
    // sticky keeps finish high throughout, hang never raises it; result is msg ^ {p,q}
    bit            sticky = 1'b0;
    bit            hang = 1'b0;
    logic [TW-1:0] junk = '0;
    logic          inv_f = 1'b0;
    logic          exp_f = 1'b0;
    int            ic = 0;
    int            ec = 0;

    always @(posedge clk) begin
        if (ctl_reset_inverter) begin
            inv_f <= sticky;
            ic    <= 3;
        end else if (ic > 0) begin
            ic <= ic - 1;
            if (ic == 1) inv_f <= ~hang;
        end
        if (ctl_reset_mod_exp) begin
            exp_f <= sticky;
            ec    <= 3;
        end else if (ec > 0) begin
            ec <= ec - 1;
            if (ec == 1) exp_f <= ~hang;
        end
    end

    assign ctl_inverter_finish = inv_f;
    assign ctl_mod_exp_finish  = exp_f;
    assign ctl_msg_out         = ctl_msg_in ^ {ctl_p, ctl_q} ^ junk;

    int n_inv = 0;
    int n_exp = 0;
    int n_both = 0;

    always @(negedge clk) begin
        if (ctl_reset_inverter) n_inv++;
        if (ctl_reset_mod_exp) n_exp++;
        if (ctl_reset_inverter && ctl_reset_mod_exp) n_both++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic job(input string tag, input logic [W-1:0] p, input logic [W-1:0] q,
                       input logic e, input logic [TW-1:0] m, input int exp_lat,
                       input int exp_inv, input logic exp_to, input logic [TW-1:0] exp_msg,
                       input bit take);
        int i0, e0, lat, g;
        @(negedge clk);
        i0 = n_inv;
        e0 = n_exp;
        req_p = p;
        req_q = q;
        req_encrypt_decrypt = e;
        req_msg = m;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk({tag, ".accept"}, TW'(g < 50), TW'(1));
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, TW'(lat), TW'(exp_lat));
        chk({tag, ".inv_pulses"}, TW'(n_inv - i0), TW'(exp_inv));
        chk({tag, ".exp_pulses"}, TW'(n_exp - e0), TW'(1));
        chk({tag, ".timeout"}, TW'(rsp_timeout), TW'(exp_to));
        chk({tag, ".msg"}, rsp_msg, exp_msg);
        chk({tag, ".enc"}, TW'(ctl_encrypt_decrypt), TW'(e));
        if (take) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    localparam logic [W-1:0]  P1 = 128'd113680897410347;
    localparam logic [W-1:0]  Q1 = 128'd7999808077935876437321;
    localparam logic [W-1:0]  P2 = 128'd8475698667747010771;
    localparam logic [W-1:0]  Q2 = 128'd11297384090418420749;
    localparam logic [TW-1:0] M1 = 256'he70000;
    localparam logic [TW-1:0] M2 = 256'h12345678;
    localparam logic [TW-1:0] K1 = {P1, Q1};
    localparam logic [TW-1:0] K2 = {P2, Q2};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.req_ready", TW'(req_ready), TW'(0));
        chk("rst.busy", TW'(busy), TW'(0));
        chk("rst.rsp_valid", TW'(rsp_valid), TW'(0));
        chk("rst.rsp_msg", rsp_msg, '0);
        chk("rst.ctl_p", TW'(ctl_p), '0);
        chk("rst.pulses", TW'({ctl_reset_inverter, ctl_reset_mod_exp}), '0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.ready_after", TW'(req_ready), TW'(1));

        job("cold", P1, Q1, 1'b0, M1, 11, 1, 1'b0, M1 ^ K1, 1'b1);
        job("hit", P1, Q1, 1'b1, M1 ^ K1, 6, 0, 1'b0, M1, 1'b1);
        job("newkey", P2, Q2, 1'b0, M2, 11, 1, 1'b0, M2 ^ K2, 1'b1);
        sticky = 1'b1;
        job("stk_hit", P2, Q2, 1'b1, M2, 4, 0, 1'b0, M2 ^ K2, 1'b1);
        job("stk_miss", P1, Q1, 1'b0, M1, 7, 1, 1'b0, M1 ^ K1, 1'b1);
        sticky = 1'b0;
        hang = 1'b1;
        job("wdog", P1, Q1, 1'b0, M1, 18, 0, 1'b1, '0, 1'b1);
        hang = 1'b0;
        job("rerun", P1, Q1, 1'b0, M1, 11, 1, 1'b0, M1 ^ K1, 1'b1);

        job("hold", P1, Q1, 1'b1, M2, 6, 0, 1'b0, M2 ^ K1, 1'b0);
        junk = '1;
        repeat (5) @(negedge clk);
        chk("hold.valid", TW'(rsp_valid), TW'(1));
        chk("hold.msg", rsp_msg, M2 ^ K1);
        junk = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold.released", TW'(rsp_valid), TW'(0));
        chk("hold.idle_ready", TW'(req_ready), TW'(1));

        @(negedge clk);
        req_p = P1;
        req_q = Q1;
        req_msg = M1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort.exp_rst", TW'(ctl_reset_mod_exp), TW'(1));
        @(negedge clk);
        chk("abort.busy", TW'(busy), TW'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("abort.outs", TW'({rsp_valid, busy, req_ready, rsp_timeout, ctl_reset_mod_exp}), '0);
        chk("abort.ctl_msg", ctl_msg_in, '0);
        chk("abort.ctl_q", TW'(ctl_q), '0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.no_rsp", TW'(rsp_valid), TW'(0));
        chk("abort.ready", TW'(req_ready), TW'(1));

        req_p = P2;
        req_q = Q2;
        req_msg = M2;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort2.inv_rst", TW'(ctl_reset_inverter), TW'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("abort2.pulse_drop", TW'(ctl_reset_inverter), TW'(0));
        reset = 1'b0;

        job("postrst", P2, Q2, 1'b0, M2, 11, 1, 1'b0, M2 ^ K2, 1'b1);
        chk("pulse_overlap", TW'(n_both), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rsa_sequencer.md
RSA_SEQUENCER -- requirements
Module: rsa_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 128, prime width; message width is 2*WIDTH.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, watchdog limit per wait state.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  job offered.
REQ-006 SHALL have port req_ready  output  1  sequencer accepts job.
REQ-007 SHALL have port req_p, req_q  input  WIDTH each  primes.
REQ-008 SHALL have port req_encrypt_decrypt  input  1  0=encrypt, 1=decrypt.
REQ-009 SHALL have port req_msg  input  2*WIDTH  input message.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-012 SHALL have port rsp_msg  output  2*WIDTH  result message.
REQ-013 SHALL have port rsp_timeout  output  1  result aborted by watchdog.
REQ-014 SHALL have ports ctl_p, ctl_q (WIDTH), ctl_encrypt_decrypt (1), ctl_msg_in (2*WIDTH)  outputs  registered operands driven to control.
REQ-015 SHALL have ports ctl_reset_inverter, ctl_reset_mod_exp  output  1  start pulses to control.
REQ-016 SHALL have ports ctl_inverter_finish, ctl_mod_exp_finish (1), ctl_msg_out (2*WIDTH)  inputs  status/result from control.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT, RESP.
REQ-019 req_ready = 1 only in IDLE; acceptance = req_valid & req_ready; operands latched into ctl_* on acceptance and held constant until next acceptance.
REQ-020 Key cache: on acceptance, if key_valid and req_p==cached_p and req_q==cached_q, go IDLE->EXP_RST (inverter skipped); otherwise go IDLE->INV_RST and set cached_p/q to the request, key_valid=0.
REQ-021 INV_RST lasts exactly 1 cycle with ctl_reset_inverter=1; then INV_WAIT.
REQ-022 INV_WAIT ignores ctl_inverter_finish in its first cycle (stale flag); from the 2nd cycle on, finish=1 -> key_valid=1, go EXP_RST.
REQ-023 EXP_RST lasts exactly 1 cycle with ctl_reset_mod_exp=1; then EXP_WAIT.
REQ-024 EXP_WAIT ignores ctl_mod_exp_finish in its first cycle; from the 2nd cycle on, finish=1 -> rsp_msg<=ctl_msg_out, rsp_timeout<=0, go RESP.
REQ-025 ctl_reset_inverter and ctl_reset_mod_exp never high simultaneously; each high only in its RST state.
REQ-026 Watchdog: counter clears on entry to each WAIT state and increments every WAIT cycle; when it reaches TIMEOUT_CYCLES without finish -> rsp_msg<=0, rsp_timeout<=1, key_valid<=0, go RESP.
REQ-027 Finish and timeout in the same cycle: finish wins.
REQ-028 RESP: rsp_valid=1, rsp_msg/rsp_timeout stable; rsp_ready=1 -> IDLE next cycle; rsp_valid stays high indefinitely otherwise.
REQ-029 No new request is accepted in the cycle RESP is exited; earliest acceptance is the cycle after.
REQ-030 Best-case latency (cache hit, finish at 2nd WAIT cycle): acceptance -> rsp_valid = 4 cycles.

Reset
REQ-031 On reset=1 at a clock edge: state=IDLE, key_valid=0, watchdog=0, all outputs 0 (req_ready=1 after reset deasserts, busy=0).
REQ-032 Reset in any state aborts the job with no response; an in-progress start pulse drops low in the same edge.

Verification
REQ-033 Cold job p=113680897410347, q=7999808077935876437321, enc=0, msg=0xe70000 -> one INV_RST pulse, one EXP_RST pulse, rsp_msg equals control model output, rsp_timeout=0.
REQ-034 Repeat same p,q with enc=1, msg=previous rsp_msg -> no ctl_reset_inverter pulse, rsp_msg=0xe70000.
REQ-035 New key p=8475698667747010771, q=11297384090418420749 after a cached key -> inverter re-run, correct result.
REQ-036 Stub holds finish=1 permanently from a prior job -> finish ignored in first WAIT cycle, accepted in 2nd; latency exactly 4 cycles on hit.
REQ-037 Stub never asserts finish, TIMEOUT_CYCLES=16 -> rsp_valid after 16 WAIT cycles, rsp_timeout=1, rsp_msg=0; next same-key job re-runs inverter.
REQ-038 reset asserted in EXP_WAIT and rsp_ready held 0 in RESP -> abort to IDLE with all outputs 0; held response stays stable until rsp_ready.
